// File: rtl/conv_rf_loader_pkg.sv
// -----------------------------------------------------------------------------
// conv_rf_loader_pkg
// Shared parameters for the convolution shift-RF loader slice. The default
// geometry matches the shift-RF macros so loader and RF agree on row shape.
// Also holds the loader state encoding and a counter-width helper.
// -----------------------------------------------------------------------------
package conv_rf_loader_pkg;

  // Default shift-RF geometry
  localparam int NUM_COL_DEF    = 8;
  localparam int NUM_ROW_DEF    = 8;
  localparam int DATA_WIDTH_DEF = 16;

  // Loader sequencing states
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ROW   = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  // Bits needed to hold every value in 0..max_value (at least one bit)
  function automatic int count_width(input int max_value);
    if (max_value < 1) begin
      return 1;
    end else begin
      return $clog2(max_value + 1);
    end
  endfunction

endpackage

// File: rtl/conv_row_packer.sv
// -----------------------------------------------------------------------------
// conv_row_packer
// Assembles incoming pixels into one shift-RF row word. Each write lands in
// column col_cnt; the column counter stops at the last column so it never
// wraps. A synchronous clear empties the buffer and rewinds the counter.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   clear     : synchronous clear of buffer and column counter
//   wr_en     : write wr_data into the current column this cycle
//   wr_data   : pixel value
//   row_word  : buffer contents with this cycle's write already merged in
//   row_done  : this cycle's write fills the last column
// -----------------------------------------------------------------------------
module conv_row_packer
  import conv_rf_loader_pkg::*;
#(
  parameter int NUM_COL    = NUM_COL_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            wr_en,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic [NUM_COL*DATA_WIDTH-1:0]   row_word,
  output logic                            row_done
);

  localparam int               COL_W   = count_width(NUM_COL - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(NUM_COL - 1);

  logic [NUM_COL*DATA_WIDTH-1:0] buf_r;
  logic [NUM_COL*DATA_WIDTH-1:0] merged_s;
  logic [COL_W-1:0]              col_cnt_r;
  logic                          row_done_s;

  // Merge the current write into the buffer image so the final beat of a row
  // is visible to the loader in the same cycle it is accepted.
  always_comb begin
    merged_s   = buf_r;
    row_done_s = wr_en && (col_cnt_r == COL_MAX);
    for (int c = 0; c < NUM_COL; c++) begin
      if (wr_en && (col_cnt_r == COL_W'(c))) begin
        merged_s[c*DATA_WIDTH +: DATA_WIDTH] = wr_data;
      end else begin
        merged_s[c*DATA_WIDTH +: DATA_WIDTH] = buf_r[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Buffer and column counter; counter holds at the last column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r     <= '0;
      col_cnt_r <= '0;
    end else if (clear) begin
      buf_r     <= '0;
      col_cnt_r <= '0;
    end else if (wr_en) begin
      buf_r <= merged_s;
      if (col_cnt_r != COL_MAX) begin
        col_cnt_r <= col_cnt_r + COL_W'(1);
      end
    end
  end

  assign row_word = merged_s;
  assign row_done = row_done_s;

endmodule

// File: rtl/conv_rf_loader.sv
// -----------------------------------------------------------------------------
// conv_rf_loader
// Streams pixels into a NUM_ROW x NUM_COL shift register file. Beats are
// packed into a row word, pushed into the RF with a row-shift strobe, and
// once NUM_ROW rows are resident every further row triggers a NUM_COL-cycle
// column sweep during which the RF holds a valid window. The final pixel of
// a frame closes the current (possibly partial) row and the frame ends with
// a one-cycle clear/done pulse. All outputs are registered and decoded from
// the next state, so strobes are mutually exclusive by construction.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   in_valid     : pixel beat valid
//   in_ready     : loader accepts a beat (high only while filling a row)
//   in_data      : pixel value
//   in_last      : last pixel of the frame (qualified by in_valid && in_ready)
//   rf_data      : row word to the RF, column 0 in the low bits
//   rf_row_shift : one-cycle row shift strobe
//   rf_col_shift : column shift strobe, high for every sweep cycle
//   rf_clear     : one-cycle RF clear strobe at end of frame
//   win_valid    : RF holds a complete window this cycle
//   frame_done   : one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module conv_rf_loader
  import conv_rf_loader_pkg::*;
#(
  parameter int NUM_COL    = NUM_COL_DEF,
  parameter int NUM_ROW    = NUM_ROW_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_last,
  output logic [NUM_COL*DATA_WIDTH-1:0] rf_data,
  output logic                          rf_row_shift,
  output logic                          rf_col_shift,
  output logic                          rf_clear,
  output logic                          win_valid,
  output logic                          frame_done
);

  localparam int               ROW_W   = count_width(NUM_ROW);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NUM_ROW);
  localparam int               SWP_W   = count_width(NUM_COL - 1);
  localparam logic [SWP_W-1:0] SWP_MAX = SWP_W'(NUM_COL - 1);

  loader_state_e                 state_r;
  loader_state_e                 state_next_s;
  logic [ROW_W-1:0]              row_cnt_r;
  logic [ROW_W-1:0]              row_inc_s;
  logic [SWP_W-1:0]              sweep_cnt_r;
  logic                          frame_last_r;

  logic                          accept_s;
  logic                          go_row_s;
  logic                          pack_clear_s;
  logic                          row_done_s;
  logic [NUM_COL*DATA_WIDTH-1:0] packed_word_s;

  logic                          in_ready_r;
  logic [NUM_COL*DATA_WIDTH-1:0] rf_data_r;
  logic                          rf_row_shift_r;
  logic                          rf_col_shift_r;
  logic                          rf_clear_r;
  logic                          win_valid_r;
  logic                          frame_done_r;

  // A beat is taken only while filling and the registered ready is high
  assign accept_s     = in_valid && in_ready_r && (state_r == ST_FILL);
  assign go_row_s     = accept_s && (row_done_s || in_last);
  assign pack_clear_s = (state_r == ST_ROW) || (state_r == ST_DONE);

  conv_row_packer #(
    .NUM_COL    (NUM_COL),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (pack_clear_s),
    .wr_en    (accept_s),
    .wr_data  (in_data),
    .row_word (packed_word_s),
    .row_done (row_done_s)
  );

  // Row count after the row being pushed now, saturating at NUM_ROW
  always_comb begin
    if (row_cnt_r == ROW_MAX) begin
      row_inc_s = row_cnt_r;
    end else begin
      row_inc_s = row_cnt_r + ROW_W'(1);
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (go_row_s) begin
          state_next_s = ST_ROW;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_ROW: begin
        if (row_inc_s == ROW_MAX) begin
          state_next_s = ST_SWEEP;
        end else if (frame_last_r) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_SWEEP: begin
        if (sweep_cnt_r != SWP_MAX) begin
          state_next_s = ST_SWEEP;
        end else if (frame_last_r) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_DONE: begin
        state_next_s = ST_FILL;
      end
      default: begin
        state_next_s = ST_FILL;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Row count, sweep count and end-of-frame flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt_r    <= '0;
      sweep_cnt_r  <= '0;
      frame_last_r <= 1'b0;
    end else begin
      if (state_r == ST_DONE) begin
        row_cnt_r <= '0;
      end else if (state_r == ST_ROW) begin
        row_cnt_r <= row_inc_s;
      end

      if ((state_r == ST_SWEEP) && (sweep_cnt_r != SWP_MAX)) begin
        sweep_cnt_r <= sweep_cnt_r + SWP_W'(1);
      end else begin
        sweep_cnt_r <= '0;
      end

      if (state_r == ST_DONE) begin
        frame_last_r <= 1'b0;
      end else if (accept_s && in_last) begin
        frame_last_r <= 1'b1;
      end
    end
  end

  // Registered outputs decoded from the state being entered; rf_data is
  // captured only when a row is pushed and holds until the next push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_r     <= 1'b0;
      rf_data_r      <= '0;
      rf_row_shift_r <= 1'b0;
      rf_col_shift_r <= 1'b0;
      rf_clear_r     <= 1'b0;
      win_valid_r    <= 1'b0;
      frame_done_r   <= 1'b0;
    end else begin
      in_ready_r     <= (state_next_s == ST_FILL);
      rf_row_shift_r <= (state_next_s == ST_ROW);
      rf_col_shift_r <= (state_next_s == ST_SWEEP);
      win_valid_r    <= (state_next_s == ST_SWEEP);
      rf_clear_r     <= (state_next_s == ST_DONE);
      frame_done_r   <= (state_next_s == ST_DONE);
      if (go_row_s) begin
        rf_data_r <= packed_word_s;
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign rf_data      = rf_data_r;
  assign rf_row_shift = rf_row_shift_r;
  assign rf_col_shift = rf_col_shift_r;
  assign rf_clear     = rf_clear_r;
  assign win_valid    = win_valid_r;
  assign frame_done   = frame_done_r;

endmodule
